ifu_fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the decode/execute stages.
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a request/response handshake.
- Presents the instruction and its PC downstream with valid/ready, then waits for the execute stage to return the next PC before fetching again. This is a multi-cycle, non-pipelined fetch loop.

---
 rtl/ifu_fetch_unit_pkg.sv | 31 +++
 rtl/ifu_timeout_counter.sv | 36 +++
 rtl/ifu_fetch_unit.sv | 91 +++++++++
 tb/tb_ifu_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit. The decode and execute
// stages use the same state encoding and widths.
//   INST_W        instruction word width
//   IFU_RESET_PC  default architectural PC after reset
//   ifu_state_e   fetch FSM states
//   ifu_inst_t    instruction record presented downstream
package ifu_fetch_unit_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_NEXT
  } ifu_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic              err;
  } ifu_inst_t;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_timeout_counter.sv
// Memory-response watchdog for the fetch unit.
//   clk, rst  clock, async active-low reset
//   clear     restart the count (held while the request is outstanding)
//   enable    one more cycle without a response
//   expired   this cycle is the TIMEOUT-th cycle without a response
// TIMEOUT=0 disables the watchdog and ties expired low.
module ifu_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_cnt
      localparam int W = $clog2(TIMEOUT + 1);
      logic [W-1:0] cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                cnt <= '0;
        else if (clear)                          cnt <= '0;
        else if (enable && cnt != W'(TIMEOUT))   cnt <= cnt + 1'b1;
      end

      // Fires on the cycle whose increment would bring the count to
      // TIMEOUT, so the FSM leaves WAIT after exactly TIMEOUT empty cycles.
      assign expired = enable && (cnt == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory, hands it downstream, then waits for the next PC from
// execute. Non-pipelined loop IDLE -> REQ -> WAIT -> OUT -> NEXT.
//   clk, rst                    clock, async active-low reset
//   imem_req_*                  fetch request (valid/ready, addr = pc)
//   imem_rsp_*                  fetch response (valid, data, bus error)
//   inst_valid/ready, inst,
//   inst_pc, inst_err           instruction record to decode
//   pc_update_valid, pc_next    next PC from execute (only heard in NEXT)
// Outputs are registers or decodes of the state register only.
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_err,
  input  logic              pc_update_valid,
  input  logic [31:0]       pc_next
);

  ifu_state_e  state;
  logic [31:0] pc;
  ifu_inst_t   out_q;
  logic        tmo_expired;

  ifu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_REQ),
    .enable  (state == S_WAIT && !imem_rsp_valid),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      out_q <= '{inst: '0, pc: RESET_PC, err: 1'b0};
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ:  if (imem_req_ready) state <= S_WAIT;
        S_WAIT: begin
          // A response in the expiry cycle still wins over the timeout.
          if (imem_rsp_valid) begin
            out_q <= '{inst: imem_rsp_data, pc: pc, err: imem_rsp_err};
            state <= S_OUT;
          end else if (tmo_expired) begin
            out_q <= '{inst: '0, pc: pc, err: 1'b1};
            state <= S_OUT;
          end
        end
        S_OUT:  if (inst_ready) state <= S_NEXT;
        S_NEXT: begin
          if (pc_update_valid) begin
            pc <= pc_next;
            if (pc_aligned(pc_next)) begin
              state <= S_REQ;
            end else begin
              // Misaligned target: report the fault without touching memory.
              out_q <= '{inst: '0, pc: pc_next, err: 1'b1};
              state <= S_OUT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_OUT);
  assign inst           = out_q.inst;
  assign inst_pc        = out_q.pc;
  assign inst_err       = out_q.err;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
module tb_ifu_fetch_unit;

  localparam int          TMO  = 4;
  localparam logic [31:0] RPC  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_err;
  logic        pc_update_valid = 1'b0;
  logic [31:0] pc_next = '0;

  int total = 0;
  int bad   = 0;

  // Reference model state: the PC the fetch unit should be working on, and
  // whether it was reached by a misaligned jump (no memory access expected).
  logic [31:0] exp_pc;
  bit          skip_mem;

  ifu_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .imem_rsp_err    (imem_rsp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_err        (inst_err),
    .pc_update_valid (pc_update_valid),
    .pc_next         (pc_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ei, input logic [31:0] ep, input logic ee);
    chk({tag, "_vld"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"}, inst, ei);
    chk({tag, "_pc"}, inst_pc, ep);
    chk({tag, "_err"}, 32'(inst_err), 32'(ee));
    chk({tag, "_noreq"}, 32'(imem_req_valid), 32'd0);
  endtask

  // One full fetch transaction, driven and checked at transaction level.
  // lat = empty WAIT cycles before the response; lat >= TMO means the memory
  // never answers and the watchdog must produce the fault.
  task automatic run_txn(input int hold_req, input int lat, input bit rerr,
                         input logic [31:0] rdata, input int hold_out,
                         input int next_dly, input logic [31:0] npc,
                         input bit wait_noise);
    logic [31:0] ei, ep;
    logic        ee;
    int          n;
    ep = exp_pc;
    if (!skip_mem) begin
      n = 0;
      while (!imem_req_valid && n < 8) begin tick(); n++; end
      chk("req_vld", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, exp_pc);
      for (int i = 0; i < hold_req; i++) begin
        imem_rsp_valid = 1'($urandom % 2);   // ignored while requesting
        imem_rsp_data  = $urandom;
        tick();
        chk("req_hold_vld", 32'(imem_req_valid), 32'd1);
        chk("req_hold_addr", imem_req_addr, exp_pc);
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("wait_noreq", 32'(imem_req_valid), 32'd0);
      if (lat < TMO) begin
        for (int i = 0; i <= lat; i++) begin
          if (wait_noise) begin
            pc_update_valid = 1'b1;
            pc_next         = $urandom;
          end
          if (i == lat) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rdata;
            imem_rsp_err   = rerr;
          end
          tick();
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        pc_update_valid = 1'b0;
        ei = rdata; ee = rerr;
      end else begin
        n = 0;
        while (!inst_valid && n < TMO + 4) begin
          pc_update_valid = wait_noise;
          pc_next         = $urandom;
          tick();
          n++;
        end
        pc_update_valid = 1'b0;
        chk("tmo_cycles", 32'(n), 32'(TMO));
        ei = '0; ee = 1'b1;
      end
    end else begin
      ei = '0; ee = 1'b1;
    end
    chk_out("out", ei, ep, ee);
    for (int i = 0; i < hold_out; i++) begin
      tick();
      chk_out("out_hold", ei, ep, ee);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("out_drop", 32'(inst_valid), 32'd0);
    for (int i = 0; i < next_dly; i++) begin
      tick();
      chk("next_novld", 32'(inst_valid), 32'd0);
      chk("next_noreq", 32'(imem_req_valid), 32'd0);
    end
    pc_update_valid = 1'b1;
    pc_next         = npc;
    tick();
    pc_update_valid = 1'b0;
    exp_pc   = npc;
    skip_mem = (npc[1:0] != 2'b00);
    if (skip_mem) chk("mis_noreq", 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] npc, r;
    int          k;
    exp_pc   = RPC;
    skip_mem = 1'b0;

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_vld", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_inst_err", 32'(inst_err), 32'd0);
    chk("rst_addr", imem_req_addr, RPC);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    chk("first_req_cyc1", 32'(imem_req_valid), 32'd1);

    // Directed: zero-wait fetch, backpressure, next-PC, faults, timeout.
    run_txn(0, 0, 1'b0, 32'h0010_0093, 0, 0, 32'h8000_0010, 1'b0);
    run_txn(3, 1, 1'b0, 32'h1234_5678, 5, 2, 32'h8000_0006, 1'b1);
    run_txn(0, 0, 1'b0, 32'h0,         1, 1, 32'h8000_0020, 1'b0);
    run_txn(1, 2, 1'b1, 32'hdead_beef, 0, 0, 32'h8000_0024, 1'b0);
    run_txn(0, 5, 1'b0, 32'h0,         2, 0, 32'h8000_0028, 1'b1);
    run_txn(0, TMO - 1, 1'b0, 32'hcafe_f00d, 0, 1, 32'h8000_0100, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    k = 0;
    while (!imem_req_valid && k < 8) begin tick(); k++; end
    chk("ar_req_addr", imem_req_addr, 32'h8000_0100);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req_vld", 32'(imem_req_valid), 32'd0);
    chk("ar_inst_vld", 32'(inst_valid), 32'd0);
    chk("ar_inst", inst, 32'd0);
    chk("ar_inst_pc", inst_pc, RPC);
    chk("ar_inst_err", 32'(inst_err), 32'd0);
    chk("ar_addr", imem_req_addr, RPC);
    imem_rsp_valid = 1'b1;          // stale response across release
    imem_rsp_data  = 32'hbad0_bad0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    chk("ar_restart_vld", 32'(imem_req_valid), 32'd1);
    chk("ar_restart_addr", imem_req_addr, RPC);
    chk("ar_stale_ignored", 32'(inst_valid), 32'd0);
    exp_pc   = RPC;
    skip_mem = 1'b0;

    // Randomized transactions against the model.
    for (int t = 0; t < 60; t++) begin
      r = $urandom;
      case (r % 8)
        0: begin
          npc = $urandom;
          npc[1:0] = 2'($urandom_range(1, 3));
        end
        1: begin
          npc = $urandom;
          npc[1:0] = 2'b00;
        end
        default: npc = exp_pc + 32'd4;
      endcase
      run_txn($urandom_range(0, 3), $urandom_range(0, TMO + 1),
              1'($urandom % 4 == 0), $urandom, $urandom_range(0, 4),
              $urandom_range(0, 3), npc, 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
